// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with write ack, overflow/underflow and level flags
module sync_fifo #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  almostfull,
    output logic                  empty,
    output logic                  almostempty
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_AFULL = CW'(FIFO_DEPTH - 1);

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [FIFO_WIDTH-1:0] r_data_out;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wa;
    logic                  w_ra;
    logic [PW-1:0]         w_wr_ptr_nxt;
    logic [PW-1:0]         w_rd_ptr_nxt;

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);
    assign w_wa    = wr_en && !w_full;
    assign w_ra    = rd_en && !w_empty;

    // Explicit wrap so depths that are not a power of two still cycle correctly.
    assign w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (w_wa) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ack    <= w_wa;
            r_overflow  <= wr_en && w_full;
            r_underflow <= rd_en && w_empty;
            if (w_wa) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            // Read only from the pre-edge state: a write into an empty FIFO is not forwarded.
            if (w_ra) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= w_rd_ptr_nxt;
            end
            if (w_wa && !w_ra) begin
                r_count <= r_count + 1'b1;
            end else if (w_ra && !w_wa) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign data_out    = r_data_out;
    assign wr_ack      = r_wr_ack;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almostfull  = (r_count == CNT_AFULL);
    assign almostempty = (r_count == CW'(1));

endmodule
